ccd_pixel_capture: RTL and testbench

//  Upstream stage of the edge-detect pipeline: samples the raw 12-bit Bayer

---
 rtl/ccd_pkg.sv | 17 +
 rtl/ccd_xy_counter.sv | 62 ++++++
 rtl/ccd_pixel_capture.sv | 145 ++++++++++++++
 tb/tb_ccd_pixel_capture.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccd_pkg.sv
// ccd_pkg: shared types and default sizes for the CCD pixel capture block.
//   ccd_state_e    capture FSM states
//   *_DEF          default parameter values used by ccd_pixel_capture
package ccd_pkg;

    localparam int unsigned DATA_W_DEF       = 12;
    localparam int unsigned CNT_W_DEF        = 11;
    localparam int unsigned COLUMN_WIDTH_DEF = 1280;
    localparam int unsigned FCNT_W_DEF       = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        ACTIVE
    } ccd_state_e;

endpackage

// File: rtl/ccd_xy_counter.sv
// ccd_xy_counter: next-pixel column/row counters for the capture stage.
//   clk_i        pixel clock
//   rst_ni       asynchronous active-low reset
//   clear_i      frame start: position returns to (0,0) this cycle
//   pixel_i      a pixel is captured this cycle
//   line_end_i   sensor line valid just fell
//   x_o / y_o    position of the pixel captured this cycle
module ccd_xy_counter #(
    parameter int unsigned CNT_W        = 11,
    parameter int unsigned COLUMN_WIDTH = 1280
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             pixel_i,
    input  logic             line_end_i,
    output logic [CNT_W-1:0] x_o,
    output logic [CNT_W-1:0] y_o
);

    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(COLUMN_WIDTH - 1);

    logic [CNT_W-1:0] nx_q, nx_d;
    logic [CNT_W-1:0] ny_q, ny_d;
    logic [CNT_W-1:0] base_x, base_y;

    // The clear applies in the same cycle so a pixel coincident with the
    // frame start is placed at (0,0).
    always_comb begin
        base_x = clear_i ? '0 : nx_q;
        base_y = clear_i ? '0 : ny_q;
        nx_d   = base_x;
        ny_d   = base_y;
        if (pixel_i) begin
            if (base_x == X_LAST) begin
                nx_d = '0;
                ny_d = base_y + CNT_W'(1);
            end else begin
                nx_d = base_x + CNT_W'(1);
            end
        end else if (line_end_i && (base_x != '0)) begin
            // Short line: move to the start of the next row. A full-width
            // line has already wrapped, so base_x is 0 and nothing happens.
            nx_d = '0;
            ny_d = base_y + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            nx_q <= '0;
            ny_q <= '0;
        end else begin
            nx_q <= nx_d;
            ny_q <= ny_d;
        end
    end

    assign x_o = base_x;
    assign y_o = base_y;

endmodule

// File: rtl/ccd_pixel_capture.sv
// ccd_pixel_capture: samples the raw Bayer sensor bus and emits the captured
// pixel stream with X/Y positions, gated to whole frames by start/stop
// requests, and counts completed captured frames.
//   iCLK, iRST          pixel clock, asynchronous active-low reset
//   iDATA, iFVAL, iLVAL sensor pixel, frame valid, line valid
//   iSTART, iEND        single-cycle capture start / stop requests
//   oDATA, oDVAL        captured pixel (0 when not valid), valid strobe
//   oX_Cont, oY_Cont    column / row of the pixel on oDATA
//   oFrame_Cont         completed captured frames (wrapping)
//   oBUSY               capture FSM not idle
module ccd_pixel_capture
    import ccd_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned COLUMN_WIDTH = COLUMN_WIDTH_DEF,
    parameter int unsigned FCNT_W       = FCNT_W_DEF
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iFVAL,
    input  logic              iLVAL,
    input  logic              iSTART,
    input  logic              iEND,
    output logic [DATA_W-1:0] oDATA,
    output logic              oDVAL,
    output logic [CNT_W-1:0]  oX_Cont,
    output logic [CNT_W-1:0]  oY_Cont,
    output logic [FCNT_W-1:0] oFrame_Cont,
    output logic              oBUSY
);

    ccd_state_e        state_q, state_d;
    logic              stop_pend_q, stop_pend_d;
    logic              fval_q;
    logic              lval_q;
    logic              dval_q, dval_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  x_q, x_d;
    logic [CNT_W-1:0]  y_q, y_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;

    logic              fval_rise;
    logic              fval_fall;
    logic              lval_fall;
    logic              cap_en;
    logic              pixel;
    logic [CNT_W-1:0]  cur_x, cur_y;

    assign fval_rise = iFVAL & ~fval_q;
    assign fval_fall = ~iFVAL & fval_q;
    assign lval_fall = ~iLVAL & lval_q;
    assign pixel     = cap_en & iFVAL & iLVAL;

    ccd_xy_counter #(
        .CNT_W       (CNT_W),
        .COLUMN_WIDTH(COLUMN_WIDTH)
    ) u_xy (
        .clk_i     (iCLK),
        .rst_ni    (iRST),
        .clear_i   (fval_rise),
        .pixel_i   (pixel),
        .line_end_i(lval_fall),
        .x_o       (cur_x),
        .y_o       (cur_y)
    );

    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        fcnt_d      = fcnt_q;
        cap_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iSTART && !iEND) begin
                    state_d = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (iEND) begin
                    state_d = IDLE;
                end else if (fval_rise) begin
                    // Capture starts on the rising edge itself.
                    state_d = ACTIVE;
                    cap_en  = 1'b1;
                end
            end
            ACTIVE: begin
                cap_en = 1'b1;
                if (iEND) begin
                    stop_pend_d = 1'b1;
                end
                if (fval_fall) begin
                    fcnt_d  = fcnt_q + FCNT_W'(1);
                    // A stop arriving on the closing cycle also takes effect.
                    state_d = (stop_pend_q || iEND) ? IDLE : WAIT_FRAME;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) begin
            stop_pend_d = 1'b0;
        end
    end

    always_comb begin
        dval_d = pixel;
        data_d = pixel ? iDATA : '0;
        x_d    = pixel ? cur_x : x_q;
        y_d    = pixel ? cur_y : y_q;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q     <= IDLE;
            stop_pend_q <= 1'b0;
            fval_q      <= 1'b0;
            lval_q      <= 1'b0;
            dval_q      <= 1'b0;
            data_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            fval_q      <= iFVAL;
            lval_q      <= iLVAL;
            dval_q      <= dval_d;
            data_q      <= data_d;
            x_q         <= x_d;
            y_q         <= y_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign oDATA       = data_q;
    assign oDVAL       = dval_q;
    assign oX_Cont     = x_q;
    assign oY_Cont     = y_q;
    assign oFrame_Cont = fcnt_q;
    assign oBUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_ccd_pixel_capture.sv
module tb_ccd_pixel_capture;

    localparam int CW = 4;

    typedef struct {
        logic [11:0] d;
        logic [10:0] x;
        logic [10:0] y;
    } pix_t;

    logic        clk;
    logic        iRST;
    logic [11:0] iDATA;
    logic        iFVAL, iLVAL, iSTART, iEND;
    logic [11:0] oDATA;
    logic        oDVAL;
    logic [10:0] oX_Cont, oY_Cont;
    logic [31:0] oFrame_Cont;
    logic        oBUSY;

    int          n_cmp = 0;
    int          n_err = 0;
    pix_t        exp_q[$];
    int          lens_q[$];
    bit          armed = 1'b0;   // capture session open (start accepted, not stopped)
    logic [31:0] fcnt  = '0;

    ccd_pixel_capture #(
        .DATA_W      (12),
        .CNT_W       (11),
        .COLUMN_WIDTH(CW),
        .FCNT_W      (32)
    ) dut (
        .iCLK       (clk),
        .iRST       (iRST),
        .iDATA      (iDATA),
        .iFVAL      (iFVAL),
        .iLVAL      (iLVAL),
        .iSTART     (iSTART),
        .iEND       (iEND),
        .oDATA      (oDATA),
        .oDVAL      (oDVAL),
        .oX_Cont    (oX_Cont),
        .oY_Cont    (oY_Cont),
        .oFrame_Cont(oFrame_Cont),
        .oBUSY      (oBUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_px(input logic [11:0] d, input int c, input int r);
        pix_t p;
        p.d = d;
        p.x = 11'(c);
        p.y = 11'(r);
        exp_q.push_back(p);
    endtask

    // Monitor: pops an expected pixel whenever the DUT presents one.
    initial begin
        pix_t p;
        forever begin
            @(posedge clk);
            #1;
            if (oDVAL === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pixel: got data=%0h x=%0d y=%0d, none expected", oDATA, oX_Cont, oY_Cont);
                end else begin
                    p = exp_q.pop_front();
                    check("pix_data", 64'(oDATA), 64'(p.d));
                    check("pix_x", 64'(oX_Cont), 64'(p.x));
                    check("pix_y", 64'(oY_Cont), 64'(p.y));
                end
            end else begin
                check("data_zero_when_invalid", 64'(oDATA), 64'(0));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One request pulse during frame blanking.
    task automatic gap_request(input bit s, input bit e);
        iFVAL  = 1'b0;
        iLVAL  = 1'b0;
        iSTART = s;
        iEND   = e;
        step();
        iSTART = 1'b0;
        iEND   = 1'b0;
        if (e) armed = 1'b0;
        else if (s) armed = 1'b1;
        step();
        check("busy_after_request", 64'(oBUSY), 64'(armed));
    endtask

    // One sensor frame built from lens_q; optional requests on its 2nd cycle.
    task automatic run_frame(input bit st_mid, input bit en_mid);
        bit cap;
        bit armed_after;
        int r, c, len;
        cap         = armed;  // frame is captured only if the session is open at its rise
        armed_after = en_mid ? 1'b0 : (st_mid ? 1'b1 : armed);
        r = 0;
        c = 0;
        iFVAL = 1'b1;
        iLVAL = 1'b0;
        step();
        iSTART = st_mid;
        iEND   = en_mid;
        step();
        iSTART = 1'b0;
        iEND   = 1'b0;
        while (lens_q.size() > 0) begin
            len = lens_q.pop_front();
            for (int i = 0; i < len; i++) begin
                iLVAL = 1'b1;
                iDATA = 12'($urandom);
                if (cap) push_px(iDATA, c, r);
                c++;
                if (c == CW) begin
                    c = 0;
                    r++;
                end
                step();
            end
            iLVAL = 1'b0;
            if (cap && c != 0) begin
                c = 0;
                r++;
            end
            step();
        end
        iFVAL = 1'b0;
        if (cap) fcnt++;
        armed = armed_after;
        step();
        repeat ($urandom_range(2, 0)) step();
        check("frame_count", 64'(oFrame_Cont), 64'(fcnt));
        check("busy_after_frame", 64'(oBUSY), 64'(armed));
    endtask

    initial begin
        iRST = 1'b0; iDATA = '0; iFVAL = 1'b0; iLVAL = 1'b0;
        iSTART = 1'b0; iEND = 1'b0;
        step();
        step();
        check("reset_dval", 64'(oDVAL), 64'(0));
        check("reset_data", 64'(oDATA), 64'(0));
        check("reset_x", 64'(oX_Cont), 64'(0));
        check("reset_y", 64'(oY_Cont), 64'(0));
        check("reset_fcnt", 64'(oFrame_Cont), 64'(0));
        check("reset_busy", 64'(oBUSY), 64'(0));
        iRST = 1'b1;
        step();

        // 4x2 frame with start issued beforehand
        gap_request(1'b1, 1'b0);
        lens_q = '{4, 4};
        run_frame(1'b0, 1'b0);

        // start arriving mid-frame skips that frame
        gap_request(1'b0, 1'b1);
        lens_q = '{4, 4};
        run_frame(1'b1, 1'b0);
        lens_q = '{4, 2};
        run_frame(1'b0, 1'b0);

        // stop mid-frame: frame completes then idle
        lens_q = '{3, 4};
        run_frame(1'b0, 1'b1);

        // short line followed by a full line; then a long line that wraps
        gap_request(1'b1, 1'b0);
        lens_q = '{3, 4};
        run_frame(1'b0, 1'b0);
        lens_q = '{6, 1};
        run_frame(1'b0, 1'b0);
        lens_q = '{};
        run_frame(1'b0, 1'b0);  // frame without any line still counts

        // start and stop together: from WAIT_FRAME -> idle, from idle stays idle
        gap_request(1'b1, 1'b1);
        gap_request(1'b1, 1'b1);
        gap_request(1'b1, 1'b0);
        gap_request(1'b1, 1'b0);  // start while busy is ignored
        gap_request(1'b0, 1'b1);
        gap_request(1'b0, 1'b1);  // stop while idle is ignored

        // randomized sessions
        for (int it = 0; it < 60; it++) begin
            int gs, ms, nl;
            gs = $urandom_range(5, 0);
            if (gs <= 1) gap_request(1'b1, 1'b0);
            else if (gs == 2) gap_request(1'b0, 1'b1);
            else if (gs == 3) gap_request(1'b1, 1'b1);
            nl = $urandom_range(3, 0);
            lens_q = '{};
            for (int k = 0; k < nl; k++) lens_q.push_back($urandom_range(9, 1));
            ms = $urandom_range(7, 0);
            run_frame(ms == 0 || ms == 2, ms == 1 || ms == 2);
        end

        // reset in the middle of a line
        gap_request(1'b1, 1'b0);
        iFVAL = 1'b1;
        iLVAL = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            iLVAL = 1'b1;
            iDATA = 12'($urandom);
            push_px(iDATA, i, 0);
            step();
        end
        iRST = 1'b0;
        #1;
        check("midreset_dval", 64'(oDVAL), 64'(0));
        check("midreset_data", 64'(oDATA), 64'(0));
        check("midreset_x", 64'(oX_Cont), 64'(0));
        check("midreset_y", 64'(oY_Cont), 64'(0));
        check("midreset_fcnt", 64'(oFrame_Cont), 64'(0));
        check("midreset_busy", 64'(oBUSY), 64'(0));
        step();
        iRST  = 1'b1;
        iFVAL = 1'b0;
        iLVAL = 1'b0;
        armed = 1'b0;
        fcnt  = '0;
        step();
        check("queue_empty_after_reset", 64'(exp_q.size()), 64'(0));

        // frame without a new start is ignored
        lens_q = '{4, 4};
        run_frame(1'b0, 1'b0);

        repeat (4) step();
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
